// File: rtl/nor_flash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nor_flash_ctrl
// Purpose  : Host-side initiator for the NOR flash array model. Accepts one
//            host request at a time (sector erase, byte program, byte read)
//            and sequences the array cmd/addr/din/wr_en interface. Programs
//            are pre-checked (NOR can only clear bits) and verified; erases
//            are verified by a full-sector blank check.
// Ports    : clk, rst            clock, synchronous active-high reset
//            i_host_req/op/addr/wdata  host request (op 01 ERASE, 10 PROG, 11 READ)
//            o_host_ready/done/err/rdata  host status and read data
//            o_f_cmd/addr/din/wr_en   array command interface
//            i_f_dout, i_f_busy       array read data and busy flag
// Revision : 1.0 - initial release
// ============================================================================
module nor_flash_ctrl #(
    parameter int SECTORS      = 4,
    parameter int SECTOR_SIZE  = 256,
    parameter int READ_LAT     = 1,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_host_req,
    input  logic [1:0]  i_host_op,
    input  logic [15:0] i_host_addr,
    input  logic [7:0]  i_host_wdata,
    output logic        o_host_ready,
    output logic        o_host_done,
    output logic        o_host_err,
    output logic [7:0]  o_host_rdata,
    output logic [1:0]  o_f_cmd,
    output logic [15:0] o_f_addr,
    output logic [7:0]  o_f_din,
    output logic        o_f_wr_en,
    input  logic [7:0]  i_f_dout,
    input  logic        i_f_busy
);

    localparam logic [1:0]  c_CMD_IDLE  = 2'b00;
    localparam logic [1:0]  c_CMD_ERASE = 2'b01;
    localparam logic [1:0]  c_CMD_WRITE = 2'b10;
    localparam logic [1:0]  c_CMD_READ  = 2'b11;
    localparam int unsigned c_ADDR_LIMIT = SECTORS * SECTOR_SIZE;
    localparam int c_IDXW    = (SECTOR_SIZE > 1) ? $clog2(SECTOR_SIZE) : 1;
    localparam int c_CNT_MAX = (BUSY_TIMEOUT > READ_LAT) ? BUSY_TIMEOUT : READ_LAT;
    localparam int c_CNTW    = $clog2(c_CNT_MAX + 1);
    localparam logic [15:0]       c_OFF_MASK     = 16'(SECTOR_SIZE - 1);
    localparam logic [c_IDXW-1:0] c_IDX_LAST     = c_IDXW'(SECTOR_SIZE - 1);
    localparam logic [c_CNTW-1:0] c_TIMEOUT_LAST = c_CNTW'(BUSY_TIMEOUT - 1);
    localparam logic [c_CNTW-1:0] c_LAT_LAST     = c_CNTW'(READ_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_ISSUE, S_RD_WAIT,
        S_PG_PRE_ISSUE, S_PG_PRE_WAIT, S_PG_WR, S_PG_VFY_ISSUE, S_PG_VFY_WAIT,
        S_ER_CMD, S_ER_WAIT, S_ER_RD_ISSUE, S_ER_RD_WAIT,
        S_REJECT, S_DONE
    } state_t;

    state_t              r_state, w_state;
    logic [c_CNTW-1:0]   r_cnt, w_cnt;
    logic [c_IDXW-1:0]   r_idx, w_idx;
    logic [15:0]         r_addr, w_addr;
    logic [7:0]          r_wdata, w_wdata;
    logic                r_ready, w_ready, r_done, w_done, r_err, w_err;
    logic [7:0]          r_rdata, w_rdata;
    logic [1:0]          r_f_cmd, w_f_cmd;
    logic [15:0]         r_f_addr, w_f_addr;
    logic [7:0]          r_f_din, w_f_din;
    logic                r_f_wr_en, w_f_wr_en;
    logic                w_held;
    logic                w_in_range;
    logic [15:0]         w_base;

    assign w_in_range = ({1'b0, i_host_addr} < 17'(c_ADDR_LIMIT));
    assign w_base     = w_addr & ~c_OFF_MASK;

    // Issue states are entered with the command already launched when the
    // array was idle at that edge; r_f_cmd==IDLE inside an issue state means
    // the launch is still being held off by f_busy.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_ready   = r_ready;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_rdata   = r_rdata;
        w_f_cmd   = c_CMD_IDLE;
        w_f_addr  = r_f_addr;
        w_f_din   = r_f_din;
        w_f_wr_en = 1'b0;
        w_held    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_host_req && (i_host_op != c_CMD_IDLE)) begin
                    w_addr  = i_host_addr;
                    w_wdata = i_host_wdata;
                    w_ready = 1'b0;
                    if (!w_in_range)                  w_state = S_REJECT;
                    else if (i_host_op == c_CMD_ERASE) w_state = S_ER_CMD;
                    else if (i_host_op == c_CMD_WRITE) w_state = S_PG_PRE_ISSUE;
                    else                               w_state = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE:     if (r_f_cmd != c_CMD_IDLE) w_state = S_RD_WAIT;     else w_held = i_f_busy;
            S_PG_PRE_ISSUE: if (r_f_cmd != c_CMD_IDLE) w_state = S_PG_PRE_WAIT; else w_held = i_f_busy;
            S_PG_WR:        if (r_f_cmd != c_CMD_IDLE) w_state = S_PG_VFY_ISSUE; else w_held = i_f_busy;
            S_PG_VFY_ISSUE: if (r_f_cmd != c_CMD_IDLE) w_state = S_PG_VFY_WAIT; else w_held = i_f_busy;
            S_ER_CMD:       if (r_f_cmd != c_CMD_IDLE) w_state = S_ER_WAIT;     else w_held = i_f_busy;
            S_ER_RD_ISSUE:  if (r_f_cmd != c_CMD_IDLE) w_state = S_ER_RD_WAIT;  else w_held = i_f_busy;
            S_ER_WAIT: begin
                if (!i_f_busy) begin
                    w_state = S_ER_RD_ISSUE;
                    w_idx   = '0;
                end else begin
                    w_held = 1'b1;
                end
            end
            S_RD_WAIT, S_PG_PRE_WAIT, S_PG_VFY_WAIT, S_ER_RD_WAIT: begin
                if (r_cnt != c_LAT_LAST) begin
                    w_cnt = r_cnt + 1'b1;
                end else if (r_state == S_RD_WAIT) begin
                    w_state = S_DONE;
                    w_rdata = i_f_dout;
                end else if (r_state == S_PG_PRE_WAIT) begin
                    // Any bit that must go 0->1 cannot be programmed.
                    if ((i_f_dout & r_wdata) != r_wdata) begin
                        w_state = S_DONE;
                        w_err   = 1'b1;
                        w_rdata = i_f_dout;
                    end else begin
                        w_state = S_PG_WR;
                    end
                end else if (r_state == S_PG_VFY_WAIT) begin
                    w_state = S_DONE;
                    w_rdata = i_f_dout;
                    w_err   = (i_f_dout != r_wdata);
                end else begin
                    if (i_f_dout != 8'hFF) begin
                        w_state = S_DONE;
                        w_err   = 1'b1;
                        w_rdata = i_f_dout;
                    end else if (r_idx == c_IDX_LAST) begin
                        w_state = S_DONE;
                        w_rdata = 8'hFF;
                    end else begin
                        w_state = S_ER_RD_ISSUE;
                        w_idx   = r_idx + 1'b1;
                    end
                end
            end
            S_REJECT: begin
                w_state = S_DONE;
                w_err   = 1'b1;
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_ready = 1'b1;
            end
            default: w_state = S_IDLE;
        endcase

        if (w_held) begin
            if (r_cnt == c_TIMEOUT_LAST) begin
                w_state = S_DONE;
                w_err   = 1'b1;
            end else begin
                w_cnt = r_cnt + 1'b1;
            end
        end

        if (w_state != r_state) w_cnt = '0;
        if ((w_state == S_DONE) && (r_state != S_DONE)) w_done = 1'b1;

        // Launch the pending command of the next issue state when the array is free.
        if (((w_state != r_state) || (r_f_cmd == c_CMD_IDLE)) && !i_f_busy) begin
            case (w_state)
                S_RD_ISSUE, S_PG_PRE_ISSUE, S_PG_VFY_ISSUE: begin
                    w_f_cmd  = c_CMD_READ;
                    w_f_addr = w_addr;
                end
                S_ER_RD_ISSUE: begin
                    w_f_cmd  = c_CMD_READ;
                    w_f_addr = w_base | 16'(w_idx);
                end
                S_ER_CMD: begin
                    w_f_cmd  = c_CMD_ERASE;
                    w_f_addr = w_base;
                end
                S_PG_WR: begin
                    w_f_cmd   = c_CMD_WRITE;
                    w_f_addr  = w_addr;
                    w_f_din   = w_wdata;
                    w_f_wr_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 8'h00;
            r_f_cmd   <= c_CMD_IDLE;
            r_f_addr  <= '0;
            r_f_din   <= '0;
            r_f_wr_en <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_ready   <= w_ready;
            r_done    <= w_done;
            r_err     <= w_err;
            r_rdata   <= w_rdata;
            r_f_cmd   <= w_f_cmd;
            r_f_addr  <= w_f_addr;
            r_f_din   <= w_f_din;
            r_f_wr_en <= w_f_wr_en;
        end
    end

    assign o_host_ready = r_ready;
    assign o_host_done  = r_done;
    assign o_host_err   = r_err;
    assign o_host_rdata = r_rdata;
    assign o_f_cmd      = r_f_cmd;
    assign o_f_addr     = r_f_addr;
    assign o_f_din      = r_f_din;
    assign o_f_wr_en    = r_f_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_nor_flash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nor_flash_ctrl
// Purpose  : Self-checking bench for nor_flash_ctrl with a behavioural NOR
//            array and a shadow-memory reference model of host operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nor_flash_ctrl;

    localparam logic [1:0] OP_ER = 2'b01, OP_PG = 2'b10, OP_RD = 2'b11;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req;
    logic [1:0]  host_op;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ready, host_done, host_err;
    logic [7:0]  host_rdata;
    logic [1:0]  f_cmd;
    logic [15:0] f_addr;
    logic [7:0]  f_din;
    logic        f_wr_en;
    logic [7:0]  f_dout;
    logic        f_busy;
    logic        fl_clear;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-operation observation log
    bit          res_done, res_err, res_after_ready, res_after_done, lg_inorder;
    logic [7:0]  res_rdata, lg_wr_din;
    int          res_lat, lg_rd_cnt, lg_wr_cnt, lg_er_cnt;
    logic [15:0] lg_rd_first, lg_rd_last, lg_er_addr, lg_wr_addr;
    logic [7:0]  sh [0:1023];

    always #5 clk = ~clk;

    nor_flash_ctrl #(.SECTORS(4), .SECTOR_SIZE(256), .READ_LAT(1), .BUSY_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_host_req(host_req), .i_host_op(host_op), .i_host_addr(host_addr),
        .i_host_wdata(host_wdata),
        .o_host_ready(host_ready), .o_host_done(host_done), .o_host_err(host_err),
        .o_host_rdata(host_rdata),
        .o_f_cmd(f_cmd), .o_f_addr(f_addr), .o_f_din(f_din), .o_f_wr_en(f_wr_en),
        .i_f_dout(f_dout), .i_f_busy(f_busy)
    );

    // Behavioural NOR array: writes can only clear bits, read data one cycle later.
    logic [7:0] fmem [0:1023];
    always @(posedge clk) begin
        if (fl_clear) begin
            for (int i = 0; i < 1024; i++) fmem[i] <= 8'hFF;
        end else begin
            case (f_cmd)
                OP_PG: if (f_wr_en) fmem[f_addr[9:0]] <= fmem[f_addr[9:0]] & f_din;
                OP_ER: for (int i = 0; i < 256; i++) fmem[{f_addr[9:8], 8'(i)}] <= 8'hFF;
                OP_RD: f_dout <= fmem[f_addr[9:0]];
                default: ;
            endcase
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [15:0] addr,
                         input logic [7:0] wd, input int limit);
        bit fin;
        @(negedge clk);
        host_req = 1'b1; host_op = op; host_addr = addr; host_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        host_req = 1'b0;
        lg_rd_cnt = 0; lg_wr_cnt = 0; lg_er_cnt = 0; lg_inorder = 1'b1;
        res_done = 1'b0; res_lat = 1; fin = 1'b0;
        while (!fin) begin
            if (f_cmd == OP_RD) begin
                if (lg_rd_cnt == 0) lg_rd_first = f_addr;
                else if (f_addr != lg_rd_last + 16'd1) lg_inorder = 1'b0;
                lg_rd_last = f_addr;
                lg_rd_cnt++;
            end
            if (f_cmd == OP_PG && f_wr_en) begin
                lg_wr_cnt++; lg_wr_din = f_din; lg_wr_addr = f_addr;
            end
            if (f_cmd == OP_ER) begin
                lg_er_cnt++; lg_er_addr = f_addr;
            end
            if (host_done) begin
                res_done = 1'b1; res_err = host_err; res_rdata = host_rdata; fin = 1'b1;
            end else if (res_lat >= limit) begin
                fin = 1'b1;
            end else begin
                @(negedge clk);
                res_lat++;
            end
        end
        @(negedge clk);
        res_after_ready = host_ready;
        res_after_done  = host_done;
    endtask

    task automatic test_reset();
        rst = 1'b1; fl_clear = 1'b1; f_busy = 1'b0;
        host_req = 1'b0; host_op = 2'b00; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < 1024; i++) sh[i] = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; fl_clear = 1'b0;
        n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", host_ready); end
        n_checks++; if (host_done !== 1'b0 || host_err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err got=%b%b exp=00", host_done, host_err); end
        n_checks++; if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", host_rdata); end
        n_checks++; if (f_cmd !== 2'b00 || f_addr !== 16'h0 || f_din !== 8'h0 || f_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_flash_if got cmd=%b addr=%h din=%h we=%b exp all 0", f_cmd, f_addr, f_din, f_wr_en); end
    endtask

    task automatic test_read();
        do_op(OP_RD, 16'h0010, 8'h00, 50);
        n_checks++; if (!res_done || res_err !== 1'b0 || res_rdata !== 8'hFF) begin n_fail++; $display("FAIL read_result done=%b err=%b rdata=%h exp 1/0/FF", res_done, res_err, res_rdata); end
        n_checks++; if (res_lat != 3) begin n_fail++; $display("FAIL read_latency got=%0d exp=3", res_lat); end
        n_checks++; if (lg_rd_cnt != 1 || lg_rd_first !== 16'h0010) begin n_fail++; $display("FAIL read_cmd got cnt=%0d addr=%h exp 1/0010", lg_rd_cnt, lg_rd_first); end
        n_checks++; if (res_after_ready !== 1'b1 || res_after_done !== 1'b0) begin n_fail++; $display("FAIL read_done_pulse got ready=%b done=%b exp 1/0", res_after_ready, res_after_done); end
    endtask

    task automatic test_program();
        do_op(OP_PG, 16'h0010, 8'hA5, 50);
        sh[16'h0010] = 8'hA5;
        n_checks++; if (!res_done || res_err !== 1'b0 || res_rdata !== 8'hA5) begin n_fail++; $display("FAIL prog_result done=%b err=%b rdata=%h exp 1/0/A5", res_done, res_err, res_rdata); end
        n_checks++; if (lg_wr_cnt != 1 || lg_wr_din !== 8'hA5 || lg_wr_addr !== 16'h0010) begin n_fail++; $display("FAIL prog_write got cnt=%0d din=%h addr=%h exp 1/A5/0010", lg_wr_cnt, lg_wr_din, lg_wr_addr); end
        n_checks++; if (res_lat != 6) begin n_fail++; $display("FAIL prog_latency got=%0d exp=6", res_lat); end
        do_op(OP_RD, 16'h0010, 8'h00, 50);
        n_checks++; if (!res_done || res_rdata !== 8'hA5) begin n_fail++; $display("FAIL prog_readback got=%h exp=A5", res_rdata); end
    endtask

    task automatic test_precheck_fail();
        do_op(OP_PG, 16'h0010, 8'h5A, 50);
        n_checks++; if (!res_done || res_err !== 1'b1 || res_rdata !== 8'hA5) begin n_fail++; $display("FAIL precheck_result done=%b err=%b rdata=%h exp 1/1/A5", res_done, res_err, res_rdata); end
        n_checks++; if (lg_wr_cnt != 0) begin n_fail++; $display("FAIL precheck_no_write got=%0d writes exp=0", lg_wr_cnt); end
        n_checks++; if (res_lat != 3) begin n_fail++; $display("FAIL precheck_latency got=%0d exp=3", res_lat); end
    endtask

    task automatic test_erase();
        do_op(OP_PG, 16'h0150, 8'h3C, 50);
        sh[16'h0150] = 8'h3C;
        do_op(OP_ER, 16'h0123, 8'h00, 2000);
        for (int i = 16'h0100; i < 16'h0200; i++) sh[i] = 8'hFF;
        n_checks++; if (!res_done || res_err !== 1'b0 || res_rdata !== 8'hFF) begin n_fail++; $display("FAIL erase_result done=%b err=%b rdata=%h exp 1/0/FF", res_done, res_err, res_rdata); end
        n_checks++; if (lg_er_cnt != 1 || lg_er_addr !== 16'h0100) begin n_fail++; $display("FAIL erase_cmd got cnt=%0d addr=%h exp 1/0100", lg_er_cnt, lg_er_addr); end
        n_checks++; if (lg_rd_cnt != 256 || lg_rd_first !== 16'h0100 || lg_rd_last !== 16'h01FF || !lg_inorder) begin
            n_fail++; $display("FAIL erase_scan got cnt=%0d first=%h last=%h inorder=%b exp 256/0100/01FF/1", lg_rd_cnt, lg_rd_first, lg_rd_last, lg_inorder); end
        n_checks++; if (res_lat != 2 + 2*256 + 1) begin n_fail++; $display("FAIL erase_latency got=%0d exp=%0d", res_lat, 2 + 2*256 + 1); end
        do_op(OP_RD, 16'h0110, 8'h00, 50);
        n_checks++; if (res_rdata !== 8'hFF) begin n_fail++; $display("FAIL erase_read_0110 got=%h exp=FF", res_rdata); end
        do_op(OP_RD, 16'h0150, 8'h00, 50);
        n_checks++; if (res_rdata !== 8'hFF) begin n_fail++; $display("FAIL erase_read_0150 got=%h exp=FF", res_rdata); end
    endtask

    task automatic test_busy_timeout();
        f_busy = 1'b1;
        do_op(OP_RD, 16'h0020, 8'h00, TIMEOUT + 100);
        f_busy = 1'b0;
        n_checks++; if (!res_done || res_err !== 1'b1) begin n_fail++; $display("FAIL busy_timeout_result done=%b err=%b exp 1/1", res_done, res_err); end
        n_checks++; if (lg_rd_cnt != 0) begin n_fail++; $display("FAIL busy_no_read got=%0d reads exp=0", lg_rd_cnt); end
        n_checks++; if (res_lat != TIMEOUT + 1) begin n_fail++; $display("FAIL busy_latency got=%0d exp=%0d", res_lat, TIMEOUT + 1); end
    endtask

    task automatic test_out_of_range();
        do_op(OP_RD, 16'h0400, 8'h00, 50);
        n_checks++; if (!res_done || res_err !== 1'b1 || res_lat != 2) begin n_fail++; $display("FAIL oor_read done=%b err=%b lat=%0d exp 1/1/2", res_done, res_err, res_lat); end
        do_op(OP_PG, 16'hFFFF, 8'h00, 50);
        n_checks++; if (!res_done || res_err !== 1'b1 || (lg_rd_cnt + lg_wr_cnt + lg_er_cnt) != 0) begin
            n_fail++; $display("FAIL oor_prog done=%b err=%b cmds=%0d exp 1/1/0", res_done, res_err, lg_rd_cnt + lg_wr_cnt + lg_er_cnt); end
    endtask

    task automatic test_ignored();
        bit bad = 1'b0;
        @(negedge clk);
        host_req = 1'b1; host_op = 2'b00; host_addr = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        host_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (host_ready !== 1'b1 || host_done !== 1'b0 || f_cmd !== 2'b00) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL op00_ignored got activity exp none"); end
    endtask

    task automatic test_back_to_back();
        int wr = 0;
        bit seen = 1'b0;
        @(negedge clk);
        host_req = 1'b1; host_op = OP_RD; host_addr = 16'h0010; host_wdata = 8'h00;
        @(posedge clk);
        @(negedge clk);
        host_op = OP_PG; host_addr = 16'h0020;   // held request while busy
        for (int i = 0; i < 10 && !seen; i++) begin
            if (f_cmd == OP_PG) wr++;
            if (host_done) begin seen = 1'b1; res_rdata = host_rdata; host_req = 1'b0; end
            else @(negedge clk);
        end
        host_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (f_cmd == OP_PG || host_done) wr++;
        end
        n_checks++; if (!seen || res_rdata !== sh[16'h0010]) begin n_fail++; $display("FAIL b2b_read seen=%b got=%h exp=%h", seen, res_rdata, sh[16'h0010]); end
        n_checks++; if (wr != 0 || host_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_not_queued got events=%0d ready=%b exp 0/1", wr, host_ready); end
    endtask

    task automatic test_reset_mid_erase();
        bit hit = 1'b0;
        bit bad = 1'b0;
        @(negedge clk);
        host_req = 1'b1; host_op = OP_ER; host_addr = 16'h0200;
        @(posedge clk);
        @(negedge clk);
        host_req = 1'b0;
        for (int i = 0; i < 700 && !hit; i++) begin
            if (f_cmd == OP_RD && f_addr == 16'h0228) hit = 1'b1;
            else @(negedge clk);
        end
        for (int i = 16'h0200; i < 16'h0300; i++) sh[i] = 8'hFF;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_scan_index40 not reached"); end
        n_checks++; if (host_ready !== 1'b1 || f_cmd !== 2'b00 || host_done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_erase got ready=%b cmd=%b done=%b exp 1/00/0", host_ready, f_cmd, host_done); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (host_done !== 1'b0 || f_cmd !== 2'b00) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL rst_no_done got activity after reset exp none"); end
        do_op(OP_RD, 16'h0010, 8'h00, 50);
        n_checks++; if (!res_done || res_err !== 1'b0 || res_rdata !== sh[16'h0010]) begin
            n_fail++; $display("FAIL rst_then_read done=%b err=%b got=%h exp=%h", res_done, res_err, res_rdata, sh[16'h0010]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [1:0]  op;
            logic [15:0] a;
            logic [7:0]  wd, old, e_rdata;
            bit          e_err;
            int          e_lat;
            op = 2'($urandom_range(1, 3));
            if (op == OP_ER && $urandom_range(0, 2) != 0) op = OP_RD;
            a  = 16'($urandom_range(0, 1151));
            wd = 8'($urandom);
            old = sh[a[9:0]];
            if (op == OP_PG && $urandom_range(0, 1) == 1) wd = wd & old;
            if (a >= 16'd1024) begin
                e_err = 1'b1; e_lat = 2; e_rdata = 8'h00;
            end else if (op == OP_RD) begin
                e_err = 1'b0; e_lat = 3; e_rdata = old;
            end else if (op == OP_PG) begin
                if ((old & wd) != wd) begin e_err = 1'b1; e_lat = 3; e_rdata = old; end
                else begin e_err = 1'b0; e_lat = 6; e_rdata = wd; sh[a[9:0]] = wd; end
            end else begin
                e_err = 1'b0; e_lat = 515; e_rdata = 8'hFF;
                for (int i = 0; i < 256; i++) sh[{a[9:8], 8'(i)}] = 8'hFF;
            end
            do_op(op, a, wd, 700);
            n_checks++; if (!res_done || res_err !== e_err || res_lat != e_lat) begin
                n_fail++; $display("FAIL rand_%0d op=%b addr=%h got done=%b err=%b lat=%0d exp 1/%b/%0d", n, op, a, res_done, res_err, res_lat, e_err, e_lat); end
            if (a < 16'd1024) begin
                n_checks++; if (res_rdata !== e_rdata) begin n_fail++; $display("FAIL rand_%0d_rdata op=%b addr=%h got=%h exp=%h", n, op, a, res_rdata, e_rdata); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_program();
        test_precheck_fail();
        test_erase();
        test_busy_timeout();
        test_out_of_range();
        test_ignored();
        test_back_to_back();
        test_reset_mid_erase();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
